// File: rtl/mul8_shift_add_seq.sv
// Sequential unsigned WIDTHxWIDTH shift-and-add multiplier controller.
// Drives an external combinational adder and shifts its {cout,sum} into the product register.
module mul8_shift_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic [WIDTH-1:0]     add_x,
  output logic [WIDTH-1:0]     add_y,
  output logic                 add_cin,
  input  logic [WIDTH:0]       add_s
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [WIDTH-1:0]     mcand_r;
  logic [2*WIDTH-1:0]   p_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 in_ready_r;
  logic                 busy_r;
  logic                 out_valid_r;

  // Next-state logic; a job always takes exactly WIDTH RUN cycles, no early exit.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_CNT) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register plus handshake flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Operand/product datapath; the adder carry becomes the new top bit of P.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r <= {WIDTH{1'b0}};
      p_r     <= {(2*WIDTH){1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            mcand_r <= in_a;
            p_r     <= {{WIDTH{1'b0}}, in_b};
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            mcand_r <= mcand_r;
            p_r     <= p_r;
            cnt_r   <= cnt_r;
          end
        end
        RUN: begin
          p_r   <= {add_s, p_r[WIDTH-1:1]};
          cnt_r <= cnt_r + CNT_W'(1);
        end
        DONE: begin
          p_r <= p_r;
        end
        default: begin
          p_r <= p_r;
        end
      endcase
    end
  end

  // Adder operands are only non-zero while RUN is accumulating.
  always_comb begin
    add_x   = {WIDTH{1'b0}};
    add_y   = {WIDTH{1'b0}};
    add_cin = 1'b0;
    if (state_r == RUN) begin
      add_x = p_r[2*WIDTH-1:WIDTH];
      if (p_r[0]) begin
        add_y = mcand_r;
      end else begin
        add_y = {WIDTH{1'b0}};
      end
    end else begin
      add_x = {WIDTH{1'b0}};
      add_y = {WIDTH{1'b0}};
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign product   = p_r;

endmodule

// File: tb/tb_mul8_shift_add_seq.sv
// Scoreboard bench for mul8_shift_add_seq with a behavioural 8-bit adder attached.
// Directed handshake/corner jobs followed by 2000 random pairs with output stalls.
module tb_mul8_shift_add_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;
  logic [7:0]  add_x;
  logic [7:0]  add_y;
  logic        add_cin;
  logic [8:0]  add_s;

  int          tests_run;
  int          tests_failed;
  int          carry_seen;
  logic [15:0] sb[$];

  mul8_shift_add_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_cin   (add_cin),
    .add_s     (add_s)
  );

  assign add_s = {1'b0, add_x} + {1'b0, add_y} + {8'b0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: score the handshakes that the coming edge will perform, then advance.
  task automatic cycle();
    logic        fire_in;
    logic        fire_out;
    logic [15:0] exp_p;
    fire_in  = in_valid && in_ready;
    fire_out = out_valid && out_ready;
    check_val("add_cin", add_cin, 0);
    if (!busy || out_valid) begin
      check_val("add_x_quiet", add_x, 0);
      check_val("add_y_quiet", add_y, 0);
    end
    if (busy && !out_valid && add_s[8]) carry_seen++;
    if (fire_out) begin
      if (sb.size() == 0) begin
        check_val("out_unexpected", out_valid, 0);
      end else begin
        exp_p = sb.pop_front();
        check_val("product", product, exp_p);
      end
    end
    if (fire_in) sb.push_back({8'h00, in_a} * {8'h00, in_b});
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      cycle();
      n++;
    end
  endtask

  task automatic run_job(input string tag, input logic [7:0] a, input logic [7:0] b);
    int n;
    out_ready = 1'b1;
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    check_val({tag, "_rdy"}, in_ready, 1);
    cycle();
    in_valid = 1'b0;
    check_val({tag, "_busy"}, busy, 1);
    wait_out(n);
    check_val({tag, "_lat"}, n, 8);
    cycle();
    check_val({tag, "_pulse"}, out_valid, 0);
    check_val({tag, "_rdy_after"}, in_ready, 1);
  endtask

  initial begin
    int n;
    int pushed;
    int cyc;
    tests_run    = 0;
    tests_failed = 0;
    carry_seen   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_add_x", add_x, 0);
    check_val("rst_add_y", add_y, 0);
    check_val("rst_add_cin", add_cin, 0);
    check_val("rst_product", product, 0);

    run_job("j3x5", 8'd3, 8'd5);

    carry_seen = 0;
    run_job("j255", 8'd255, 8'd255);
    check_val("carry_seen", carry_seen > 0, 1);

    run_job("j0x200", 8'd0, 8'd200);
    run_job("j200x0", 8'd200, 8'd0);

    // Stalled output with stray in_valid pulses while not idle.
    out_ready = 1'b0;
    in_a      = 8'd12;
    in_b      = 8'd10;
    in_valid  = 1'b1;
    cycle();
    n = 0;
    while (!out_valid && n < 30) begin
      in_valid = n[0];
      in_a     = 8'd1;
      in_b     = 8'd1;
      check_val("stall_rdy_run", in_ready, 0);
      cycle();
      n++;
    end
    check_val("stall_lat", n, 8);
    for (int i = 0; i < 3; i++) begin
      in_valid = (i == 1);
      check_val("stall_valid", out_valid, 1);
      check_val("stall_product", product, 16'h0078);
      check_val("stall_rdy_done", in_ready, 0);
      cycle();
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    check_val("take_rdy_done", in_ready, 0);
    cycle();
    check_val("idle_rdy", in_ready, 1);
    check_val("idle_valid", out_valid, 0);
    cycle();
    in_valid = 1'b0;
    wait_out(n);
    check_val("next_lat", n, 8);
    cycle();

    // Reset in the middle of RUN discards the job.
    in_a     = 8'd50;
    in_b     = 8'd60;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (4) cycle();
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", out_valid, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_rdy", in_ready, 1);
    check_val("mid_rst_product", product, 0);
    check_val("mid_rst_add_x", add_x, 0);
    sb.delete();
    @(negedge clk);
    check_val("in_rst_valid", out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_job("j7x9", 8'd7, 8'd9);

    // Random scoreboard phase.
    pushed = 0;
    cyc    = 0;
    while ((pushed < 2000 || sb.size() != 0) && cyc < 60000) begin
      in_valid  = (pushed < 2000) && ($urandom_range(0, 1) == 1);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) pushed++;
      cycle();
      cyc++;
    end
    in_valid = 1'b0;
    check_val("rand_pushed", pushed, 2000);
    check_val("rand_drain", sb.size(), 0);
    check_val("rand_in_time", cyc < 60000, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
